y86_fetch_prefetch: RTL
=======================

Name: y86_fetch_prefetch

Overview:
Parametrised successor to the SEQ fetch stage. It decouples Y86-64 instruction fetch from the instruction memory through a byte prefetch buffer. It issues multi-byte memory beats and decodes the buffer head into icode/ifun/rA/rB/valC/valP, presented under a valid/ready handshake. It adds PC redirect (for jumps, call and ret from later stages), halt/invalid/memory-error stop states, and backpressure. Sits between instruction memory and decode in the pipelined core.

Parameters:
ADDR_W, 64, PC and memory address width.
FETCH_BYTES, 2, bytes returned per memory beat (1, 2, 4 or 8).
BUF_BYTES, 16, prefetch buffer depth in bytes; must be >= 10+FETCH_BYTES.
MEM_BYTES, 1024, size of the legal instruction address space; addresses >= MEM_BYTES are errors.
RESET_PC, 0, PC after reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
redirect  in  1  load new PC and flush the buffer.
redirect_pc  in  ADDR_W  target PC for redirect.
mem_req_valid  out  1  memory read request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  ADDR_W  beat start address.
mem_rsp_valid  in  1  response data valid; at most one outstanding request.
mem_rsp_data  in  8*FETCH_BYTES  beat bytes; lowest address in bits [7:0].
out_valid  out  1  decoded instruction available.
out_ready  in  1  consumer accepts the instruction.
pc_out  out  ADDR_W  PC of the presented instruction.
icode  out  4  high nibble of byte 0.
ifun  out  4  low nibble of byte 0.
rA  out  4  high nibble of byte 1; 0xF if the instruction has no register byte.
rB  out  4  low nibble of byte 1; 0xF if the instruction has no register byte.
valC  out  64  little-endian constant; 0 if the instruction has none.
valP  out  ADDR_W  pc_out + instruction length.
instr_valid  out  1  0 when icode > 0xB.
imem_error  out  1  instruction would cross or start at or beyond MEM_BYTES.
halt  out  1  icode == 0.

Behaviour:
- Reset (asynchronous): state RUN. pc = fetch_ptr = RESET_PC. Buffer count 0, no request outstanding. All outputs 0; rA/rB = 0.
- Instruction lengths by icode:
  - 0, 1, 9 = 1 byte.
  - 2, 6, A, B = 2 bytes.
  - 3, 4, 5 = 10 bytes; valC from bytes 2..9.
  - 7, 8 = 9 bytes; valC from bytes 1..8.
  - Invalid icode = 1 byte.
- Fetch: in RUN, assert mem_req_valid with addr = fetch_ptr when all of these hold: free space >= FETCH_BYTES, no request outstanding, fetch_ptr < MEM_BYTES.
  - The request is held stable until mem_req_ready.
  - On acceptance, fetch_ptr += FETCH_BYTES.
  - On mem_rsp_valid, append all FETCH_BYTES bytes in the same cycle.
- Decode is combinational from the buffer head; outputs are valid only while out_valid = 1.
  - out_valid = 1 in RUN when count >= length(head icode).
  - Also out_valid = 1 when count is insufficient but fetch_ptr >= MEM_BYTES; the instruction is then presented with imem_error = 1 and the other fields don't-care.
  - out_valid is 0 when count is 0 and no error applies.
- Consume: when out_valid && out_ready, pop length bytes and set pc = valP. A pop and an append in the same cycle are both applied.
- Stop states: consuming an instruction with halt = 1, instr_valid = 0 or imem_error = 1 moves to STOP.
  - STOP keeps out_valid = 0 and mem_req_valid = 0.
  - Only redirect or reset leaves STOP.
- Redirect (any state): in the next cycle pc = fetch_ptr = redirect_pc, buffer emptied, state RUN.
  - A consume in the same cycle is ignored.
  - A response arriving in the same cycle as redirect, or for a request issued before it, is discarded via a drop flag.
  - A request held but not yet accepted is withdrawn.
- Backpressure: while out_ready = 0, outputs are held stable. Prefetch continues until the buffer is full.
- Wrap-around: buffer pointers wrap modulo BUF_BYTES. The PC never wraps; addresses beyond MEM_BYTES raise the error.

Test Plan:
- Stream at 0: 10; 22 BC; 30 F2 + 145 LE; 00, with out_ready = 1. Expected sequence:
  - nop: pc 0, valP 1.
  - cmovl: ifun 2, rA 0xB, rB 0xC, valP 3.
  - irmovq: rA F, rB 2, valC 145, valP 13.
  - halt: pc 13, halt = 1.
  - Then STOP with no further requests.
- Same stream with out_ready low for 20 cycles: pc_out/icode stay at 0/1 throughout; buffer fills to BUF_BYTES and mem_req_valid drops.
- jXX 73 + dest 50 at 35, then redirect to 50 while a response is outstanding: the stale response is dropped; the next out_valid has pc_out 50 with bytes from 50.
- Byte 0xC0 at 5: instr_valid = 0, valP 6; after consume, out_valid stays 0 until redirect.
- irmovq at MEM_BYTES-4: out_valid with imem_error = 1 and no request at addresses >= MEM_BYTES; redirect to 0 recovers.
- rst_n low mid-fetch with a request pending: mem_req_valid and out_valid drop immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/y86_fetch_prefetch.sv
// Y86-64 fetch stage with a byte prefetch buffer between instruction memory and decode.
// Handles PC redirect, halt/invalid/memory-error stop states and consumer backpressure.
module y86_fetch_prefetch #(
  parameter int ADDR_W      = 64,
  parameter int FETCH_BYTES = 2,
  parameter int BUF_BYTES   = 16,
  parameter int MEM_BYTES   = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [8*FETCH_BYTES-1:0] mem_rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        pc_out,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [ADDR_W-1:0]        valP,
  output logic                     instr_valid,
  output logic                     imem_error,
  output logic                     halt
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = $clog2(BUF_BYTES + 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] BEAT      = ADDR_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0]  BEAT_C    = CNT_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(BUF_BYTES);

  typedef enum logic {RUN, STOP} state_t;

  state_t             state, state_next;
  logic [7:0]         buf_q [BUF_BYTES];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count, count_next;
  logic [ADDR_W-1:0]  pc, fetch_ptr, next_pc;
  logic               started, outstanding, drop;

  logic [7:0]         win [10];
  logic [3:0]         hi_code, lo_fun, len;
  logic               has_regs;
  logic [63:0]        const_val;
  logic [CNT_W-1:0]   len_c;
  logic               starved, fetch_done, range_err, bad_code, stop_cond;
  logic               present, shown, fire, pop, push, req, req_fire;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= BUF_BYTES) s = s - BUF_BYTES;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 10; i++) win[i] = buf_q[wrap_add(head, 32'(i))];
  end

  // Length, register-byte presence and constant placement all follow from the icode nibble
  always_comb begin
    hi_code   = win[0][7:4];
    lo_fun    = win[0][3:0];
    len       = 4'd1;
    has_regs  = 1'b0;
    const_val = '0;
    case (hi_code)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        len      = 4'd2;
        has_regs = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        len       = 4'd10;
        has_regs  = 1'b1;
        const_val = {win[9], win[8], win[7], win[6], win[5], win[4], win[3], win[2]};
      end
      4'h7, 4'h8: begin
        len       = 4'd9;
        const_val = {win[8], win[7], win[6], win[5], win[4], win[3], win[2], win[1]};
      end
      default: len = 4'd1;
    endcase
  end

  assign len_c      = CNT_W'(len);
  assign next_pc    = pc + ADDR_W'(len);
  assign starved    = (count == '0) || (count < len_c);
  assign fetch_done = fetch_ptr >= MEM_LIMIT;
  assign range_err  = starved || (pc >= MEM_LIMIT) || (next_pc > MEM_LIMIT);
  assign bad_code   = hi_code > 4'hB;
  assign stop_cond  = range_err || bad_code || (hi_code == 4'h0);

  // A starved head is only reported as an error once no more bytes can ever arrive
  assign present  = started && (state == RUN) && (!starved || (fetch_done && !outstanding));
  assign shown    = present && !starved;
  assign fire     = present && out_ready && !redirect;
  assign pop      = fire && !starved;
  assign push     = mem_rsp_valid && outstanding && !drop && !redirect;
  assign req      = started && (state == RUN) && !outstanding && !fetch_done &&
                    ((DEPTH_C - count) >= BEAT_C);
  assign req_fire = req && mem_req_ready;

  always_comb begin
    count_next = count;
    if (push) count_next = count_next + BEAT_C;
    if (pop)  count_next = count_next - len_c;
  end

  always_comb begin
    state_next = state;
    if (redirect) state_next = RUN;
    else if (fire && stop_cond) state_next = STOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      pc          <= RESET_PC;
      fetch_ptr   <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        pc        <= redirect_pc;
        fetch_ptr <= redirect_pc;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        // Whatever is still in flight belongs to the old stream and must be thrown away
        if (req_fire) begin
          outstanding <= 1'b1;
          drop        <= 1'b1;
        end else if (mem_rsp_valid) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end else begin
          drop <= outstanding;
        end
      end else begin
        if (req_fire) begin
          fetch_ptr   <= fetch_ptr + BEAT;
          outstanding <= 1'b1;
        end
        if (mem_rsp_valid && outstanding) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end
        if (push) tail <= wrap_add(tail, 32'(FETCH_BYTES));
        if (pop)  head <= wrap_add(head, 32'(len));
        count <= count_next;
        if (fire) pc <= next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_BYTES; i++)
        buf_q[wrap_add(tail, 32'(i))] <= mem_rsp_data[8*i +: 8];
    end
  end

  assign mem_req_valid = req;
  assign mem_req_addr  = req ? fetch_ptr : '0;
  assign out_valid     = present;
  assign pc_out        = present ? pc : '0;
  assign valP          = present ? next_pc : '0;
  assign icode         = shown ? hi_code : 4'h0;
  assign ifun          = shown ? lo_fun : 4'h0;
  assign rA            = shown ? (has_regs ? win[1][7:4] : 4'hF) : 4'h0;
  assign rB            = shown ? (has_regs ? win[1][3:0] : 4'hF) : 4'h0;
  assign valC          = shown ? const_val : '0;
  assign instr_valid   = shown && !bad_code;
  assign halt          = shown && (hi_code == 4'h0);
  assign imem_error    = present && range_err;

endmodule
